// File: rtl/md_unit.sv
// EX-stage multiply/divide unit holding the architectural HI/LO pair.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MDU_MADD_EN.
module md_unit #(
  parameter int unsigned MUL_CYCLES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        valid,
  input  logic        cancel,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  state_t      state, state_n;
  logic [5:0]  cnt;
  logic [63:0] mres;
  logic [31:0] dq, dd, rem;
  logic        neg_q, neg_r;

  logic is_mul, is_mac, is_div;
  logic is_mthi, is_mtlo;
  logic accept, go_mul, go_div;

  assign is_mul  = (op == 4'd1) || (op == 4'd2);
  assign is_div  = (op == 4'd3) || (op == 4'd4);
  assign is_mthi = (op == 4'd5);
  assign is_mtlo = (op == 4'd6);
`ifdef MDU_MADD_EN
  assign is_mac  = (op >= 4'd7) && (op <= 4'd10);
`else
  assign is_mac  = 1'b0;
`endif

  assign busy   = (state != IDLE);
  assign stall  = busy | (start & valid & (is_mul | is_mac | is_div));
  assign accept = start & valid & ~cancel & ~busy;
  assign go_mul = accept & (is_mul | is_mac);
  assign go_div = accept & is_div & (b != 32'd0);

  // Sign-extended 64x64 keeps the low 64 bits exact for the signed case.
  logic        sgn_mul;
  logic [63:0] prod_s, prod_u, prod, mul_res;

  assign sgn_mul = (op == 4'd1) || (op == 4'd7) || (op == 4'd9);
  assign prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u  = {32'd0, a} * {32'd0, b};
  assign prod    = sgn_mul ? prod_s : prod_u;

`ifdef MDU_MADD_EN
  logic mac_sub;
  assign mac_sub = (op == 4'd9) || (op == 4'd10);
  assign mul_res = !is_mac ? prod :
                   mac_sub ? {hi, lo} - prod :
                             {hi, lo} + prod;
`else
  assign mul_res = prod;
`endif

  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic [32:0] rem_sh, diff;
  logic        ge;

  assign a_neg  = (op == 4'd3) & a[31];
  assign b_neg  = (op == 4'd3) & b[31];
  assign a_abs  = a_neg ? -a : a;
  assign b_abs  = b_neg ? -b : b;
  assign rem_sh = {rem, dq[31]};
  assign diff   = rem_sh - {1'b0, dd};
  assign ge     = ~diff[32];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (go_mul)      state_n = MUL;
        else if (go_div) state_n = DIV;
      end
      MUL:  if (cnt == 6'd1) state_n = IDLE;
      DIV:  if (cnt == 6'd1) state_n = FIX;
      FIX:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      mres  <= '0;
      dq    <= '0;
      dd    <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go_mul) begin
            mres <= mul_res;
            cnt  <= 6'(MUL_CYCLES);
          end else if (go_div) begin
            dq    <= a_abs;
            dd    <= b_abs;
            rem   <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            cnt   <= 6'd32;
          end else if (accept & is_mthi) begin
            hi <= a;
          end else if (accept & is_mtlo) begin
            lo <= a;
          end
        end
        MUL: begin
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) {hi, lo} <= mres;
        end
        DIV: begin
          cnt <= cnt - 6'd1;
          dq  <= {dq[30:0], ge};
          rem <= ge ? diff[31:0] : rem_sh[31:0];
        end
        FIX: begin
          lo <= neg_q ? -dq : dq;
          hi <= neg_r ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed cases plus random ops against a 64-bit
// arithmetic reference of HI/LO, busy length and stall.
module tb_md_unit;

  localparam int MC = 5;

`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, valid, cancel;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] mhi, mlo;

  md_unit #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .reset(reset), .start(start), .valid(valid),
    .cancel(cancel), .op(op), .a(a), .b(b),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_is_mul(input logic [3:0] o);
    return (o == 4'd1) || (o == 4'd2) || (MADD && o >= 4'd7 && o <= 4'd10);
  endfunction

  function automatic bit m_stall(input logic [3:0] o);
    return m_is_mul(o) || (o == 4'd3) || (o == 4'd4);
  endfunction

  function automatic int m_busy(input logic [3:0] o, input logic [31:0] y);
    if (m_is_mul(o)) return MC;
    if ((o == 4'd3 || o == 4'd4) && y != 0) return 33;
    return 0;
  endfunction

  // Reference: HI/LO computed with plain 64-bit integer arithmetic.
  task automatic model(input logic [3:0] o, input logic [31:0] x, y);
    longint sx, sy, q, r;
    logic [63:0] p, acc;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    acc = {mhi, mlo};
    case (o)
      4'd1: {mhi, mlo} = sx * sy;
      4'd2: {mhi, mlo} = {32'd0, x} * {32'd0, y};
      4'd3: if (y != 0) begin
        q = sx / sy;
        r = sx % sy;
        mlo = q[31:0];
        mhi = r[31:0];
      end
      4'd4: if (y != 0) begin
        mlo = x / y;
        mhi = x % y;
      end
      4'd5: mhi = x;
      4'd6: mlo = x;
      4'd7, 4'd8, 4'd9, 4'd10: if (MADD) begin
        if (o == 4'd7 || o == 4'd9) p = sx * sy;
        else p = {32'd0, x} * {32'd0, y};
        if (o >= 4'd9) {mhi, mlo} = acc - p;
        else {mhi, mlo} = acc + p;
      end
      default: ;
    endcase
  endtask

  task automatic do_op(input string tag, input logic [3:0] o,
                       input logic [31:0] x, y, input logic c);
    int n;
    int eb;
    eb = c ? 0 : m_busy(o, y);
    @(negedge clk);
    start = 1'b1; valid = 1'b1; cancel = c; op = o; a = x; b = y;
    #1 chk({tag, ".stall"}, 64'(stall), 64'(m_stall(o)));
    @(posedge clk);
    #1;
    start = 1'b0; valid = 1'b0; cancel = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      chk({tag, ".hold"}, {hi, lo}, {mhi, mlo});
      @(posedge clk);
      #1 n++;
    end
    chk({tag, ".busy_len"}, 64'(n), 64'(eb));
    if (!c) model(o, x, y);
    chk({tag, ".hilo"}, {hi, lo}, {mhi, mlo});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; valid = 1'b0; cancel = 1'b0;
    op = 4'd0; a = '0; b = '0;
    mhi = '0; mlo = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset.hilo", {hi, lo}, 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.stall", 64'(stall), 64'd0);

    do_op("mult", 4'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
    chk("mult.const", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    do_op("multu", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("multu.const", {hi, lo}, 64'hFFFFFFFE_00000001);
    do_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div.const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op("divu", 4'd4, 32'd100, 32'd7, 1'b0);
    chk("divu.const", {hi, lo}, {32'd2, 32'd14});
    do_op("mthi", 4'd5, 32'h11, 32'd0, 1'b0);
    do_op("mtlo", 4'd6, 32'h22, 32'd0, 1'b0);
    do_op("divz", 4'd4, 32'd7, 32'd0, 1'b0);
    chk("divz.const", {hi, lo}, {32'h11, 32'h22});
    do_op("divmin", 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("divmin.const", {hi, lo}, {32'd0, 32'h80000000});

    // MTHI presented while a MULT is in flight must be ignored.
    @(negedge clk);
    start = 1'b1; valid = 1'b1; op = 4'd1; a = 32'd6; b = 32'hFFFFFFF9;
    @(posedge clk);
    #1 op = 4'd5; a = 32'h1234;
    chk("busy_mthi.stall", 64'(stall), 64'd1);
    @(posedge clk);
    #1 start = 1'b0; valid = 1'b0;
    chk("busy_mthi.hold", {hi, lo}, {mhi, mlo});
    for (int i = 0; i < 20 && busy === 1'b1; i++) @(posedge clk);
    #1 model(4'd1, 32'd6, 32'hFFFFFFF9);
    chk("busy_mthi.busy", 64'(busy), 64'd0);
    chk("busy_mthi.hilo", {hi, lo}, {mhi, mlo});

    do_op("mthi_cancel", 4'd5, 32'h1234, 32'd0, 1'b1);
    do_op("mult_cancel", 4'd1, 32'd9, 32'd9, 1'b1);
    do_op("mthi_ok", 4'd5, 32'h1234, 32'd0, 1'b0);
    chk("mthi_ok.const", 64'(hi), 64'h1234);

`ifdef MDU_MADD_EN
    do_op("madd.pre_hi", 4'd5, 32'd0, 32'd0, 1'b0);
    do_op("madd.pre_lo", 4'd6, 32'd10, 32'd0, 1'b0);
    do_op("madd", 4'd7, 32'd3, 32'd4, 1'b0);
    chk("madd.const", {hi, lo}, 64'd22);
    do_op("msubu", 4'd10, 32'hFFFFFFFF, 32'd2, 1'b0);
    chk("msubu.const", {hi, lo}, 64'hFFFFFFFE_00000018);
`else
    do_op("madd_off", 4'd7, 32'd3, 32'd4, 1'b0);
    do_op("msubu_off", 4'd10, 32'hFFFFFFFF, 32'd2, 1'b0);
`endif

    for (int i = 0; i < 30; i++) begin
      logic [3:0]  ro;
      logic [31:0] rx, ry;
      logic        rc;
      ro = 4'($urandom_range(0, 12));
      rx = $urandom;
      ry = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(1, 20));
      rc = ($urandom_range(0, 6) == 0);
      do_op("rand", ro, rx, ry, rc);
    end

    // Reset in the middle of a divide abandons it.
    @(negedge clk);
    start = 1'b1; valid = 1'b1; op = 4'd3; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0; valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 chk("rst_div.busy_mid", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    mhi = '0; mlo = '0;
    chk("rst_div.hilo", {hi, lo}, {mhi, mlo});
    chk("rst_div.busy", 64'(busy), 64'd0);
    repeat (40) @(posedge clk);
    #1 chk("rst_div.later", {hi, lo}, {mhi, mlo});
    chk("rst_div.later_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
